// File: rtl/avaliador_rodada.sv
// avaliador_rodada: round evaluator that requests scores from the score calculator.
//
// Walks the player through rounds 0..NUM_RODADAS-1. Round r expects r+1 notes read from the
// sequence memory at `endereco`. Wrong notes are counted per round; at round end `calcular` is
// held for CALC_LAT cycles with stable `rodada`/`erros`, then `pontos_calc` is latched into
// `pontos`, which feeds back as the calculator's pontos_in.
//
// Ports:
//   clock, reset_n   clock (rising edge) and asynchronous active-low reset
//   iniciar          start-game strobe (ignored while ocupado)
//   jogada           one-cycle strobe qualifying nota_jogada
//   nota_jogada      note played
//   nota_esperada    sequence memory data at endereco (combinational read)
//   pontos_calc      calculator result
//   endereco         sequence memory address (note index within the round)
//   rodada, erros    current round and its error count, to the calculator
//   calcular         calculator trigger
//   pontos           accumulated score
//   ocupado          game in progress
//   fim_jogo         game finished
//
// Optional feature: define TIMEOUT_JOGADA_EN to count a missed note as an error after
// TIMEOUT_CICLOS idle cycles in the note-wait state.

module avaliador_rodada #(
  parameter int unsigned NOTA_W         = 4,
  parameter int unsigned NUM_RODADAS    = 16,
  parameter int unsigned CALC_LAT       = 2,
  parameter int unsigned TIMEOUT_CICLOS = 1000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              iniciar,
  input  logic              jogada,
  input  logic [NOTA_W-1:0] nota_jogada,
  input  logic [NOTA_W-1:0] nota_esperada,
  input  logic [7:0]        pontos_calc,
  output logic [3:0]        endereco,
  output logic [3:0]        rodada,
  output logic [7:0]        erros,
  output logic              calcular,
  output logic [7:0]        pontos,
  output logic              ocupado,
  output logic              fim_jogo
);

  localparam int unsigned LatW = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;
  localparam logic [LatW-1:0] UltimaLat = LatW'(CALC_LAT - 1);
  localparam logic [3:0] UltimaRodada = 4'(NUM_RODADAS - 1);

  typedef enum logic [2:0] {
    StOcioso,
    StEspera,
    StFimRodada,
    StRegistra,
    StFim
  } estado_e;

  estado_e         estado_q, estado_d;
  logic [LatW-1:0] lat_q, lat_d;
  logic [3:0]      endereco_q, endereco_d;
  logic [3:0]      rodada_q, rodada_d;
  logic [7:0]      erros_q, erros_d;
  logic [7:0]      pontos_q, pontos_d;
  logic            calcular_q, calcular_d;
  logic            ocupado_q, ocupado_d;
  logic            fim_jogo_q, fim_jogo_d;

  logic timeout;      // idle timeout fired this cycle (never with a jogada)
  logic evento;       // a note was consumed this cycle (played or timed out)
  logic erro_evento;  // the consumed note counts as an error
  logic ultima_nota;  // current note is the last of the round

`ifdef TIMEOUT_JOGADA_EN
  logic [15:0] ocioso_q, ocioso_d;

  assign timeout = (estado_q == StEspera) && !jogada &&
                   (ocioso_q == 16'(TIMEOUT_CICLOS - 1));

  // Held at zero outside ESPERA, so entering ESPERA always starts from zero.
  always_comb begin
    ocioso_d = ocioso_q;
    if (estado_q != StEspera || jogada || timeout) begin
      ocioso_d = '0;
    end else begin
      ocioso_d = ocioso_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ocioso_q <= '0;
    end else begin
      ocioso_q <= ocioso_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CICLOS;
  assign timeout = 1'b0;
`endif

  // jogada wins over a simultaneous timeout.
  assign evento      = (estado_q == StEspera) && (jogada || timeout);
  assign erro_evento = jogada ? (nota_jogada != nota_esperada) : timeout;
  assign ultima_nota = (endereco_q == rodada_q);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q   <= StOcioso;
      lat_q      <= '0;
      endereco_q <= '0;
      rodada_q   <= '0;
      erros_q    <= '0;
      pontos_q   <= '0;
      calcular_q <= 1'b0;
      ocupado_q  <= 1'b0;
      fim_jogo_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      lat_q      <= lat_d;
      endereco_q <= endereco_d;
      rodada_q   <= rodada_d;
      erros_q    <= erros_d;
      pontos_q   <= pontos_d;
      calcular_q <= calcular_d;
      ocupado_q  <= ocupado_d;
      fim_jogo_q <= fim_jogo_d;
    end
  end

  // Next-state logic.
  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      StOcioso, StFim: if (iniciar) estado_d = StEspera;
      StEspera:        if (evento && ultima_nota) estado_d = StFimRodada;
      StFimRodada:     if (lat_q == UltimaLat) estado_d = StRegistra;
      StRegistra:      estado_d = (rodada_q == UltimaRodada) ? StFim : StEspera;
      default:         estado_d = StOcioso;
    endcase
  end

  // Datapath and registered outputs; flags follow the state being entered.
  always_comb begin
    endereco_d = endereco_q;
    rodada_d   = rodada_q;
    erros_d    = erros_q;
    pontos_d   = pontos_q;
    calcular_d = (estado_d == StFimRodada);
    ocupado_d  = (estado_d inside {StEspera, StFimRodada, StRegistra});
    fim_jogo_d = (estado_d == StFim);
    lat_d      = (estado_q == StFimRodada && estado_d == StFimRodada) ? lat_q + LatW'(1) : '0;

    unique case (estado_q)
      StOcioso, StFim: begin
        if (iniciar) begin
          endereco_d = '0;
          rodada_d   = '0;
          erros_d    = '0;
          pontos_d   = '0;
        end
      end
      StEspera: begin
        if (evento) begin
          if (erro_evento && erros_q != 8'hFF) erros_d = erros_q + 8'd1;
          if (!ultima_nota) endereco_d = endereco_q + 4'd1;
        end
      end
      StRegistra: begin
        pontos_d   = pontos_calc;
        erros_d    = '0;
        endereco_d = '0;
        if (rodada_q != UltimaRodada) rodada_d = rodada_q + 4'd1;
      end
      default: ;
    endcase
  end

  assign endereco = endereco_q;
  assign rodada   = rodada_q;
  assign erros    = erros_q;
  assign calcular = calcular_q;
  assign pontos   = pontos_q;
  assign ocupado  = ocupado_q;
  assign fim_jogo = fim_jogo_q;

endmodule

// File: tb/tb_avaliador_rodada.sv
module tb_avaliador_rodada;

  localparam int NUM_RODADAS = 16;
  localparam int CALC_LAT    = 2;
  localparam int TIMEOUT     = 10;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b1;
  logic       iniciar = 1'b0;
  logic       jogada  = 1'b0;
  logic [3:0] nota_jogada = 4'h0;
  logic [3:0] nota_esperada;
  logic [7:0] pontos_calc;
  logic [3:0] endereco, rodada;
  logic [7:0] erros, pontos;
  logic       calcular, ocupado, fim_jogo;

  logic [3:0] seq [16];
  logic       calc_inc = 1'b0;
  logic [7:0] calc_val = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  assign nota_esperada = seq[endereco];
  assign pontos_calc   = calc_inc ? pontos + 8'd1 : calc_val;

  avaliador_rodada #(
    .NOTA_W        (4),
    .NUM_RODADAS   (NUM_RODADAS),
    .CALC_LAT      (CALC_LAT),
    .TIMEOUT_CICLOS(TIMEOUT)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .iniciar      (iniciar),
    .jogada       (jogada),
    .nota_jogada  (nota_jogada),
    .nota_esperada(nota_esperada),
    .pontos_calc  (pontos_calc),
    .endereco     (endereco),
    .rodada       (rodada),
    .erros        (erros),
    .calcular     (calcular),
    .pontos       (pontos),
    .ocupado      (ocupado),
    .fim_jogo     (fim_jogo)
  );

  task automatic check(input string nome, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", nome, $time, got, exp);
    end
  endtask

  // Game model: phases of play rather than hardware states.
  localparam int FaseOcioso = 0, FaseJoga = 1, FaseCalc = 2, FaseReg = 3, FaseFim = 4;
  int m_fase = FaseOcioso;
  int m_rod = 0, m_err = 0, m_end = 0, m_pts = 0, m_idle = 0, m_calc_rest = 0;
  logic ev, err;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_fase = FaseOcioso;
      m_rod = 0; m_err = 0; m_end = 0; m_pts = 0; m_idle = 0; m_calc_rest = 0;
    end else begin
      case (m_fase)
        FaseOcioso, FaseFim: begin
          if (iniciar) begin
            m_rod = 0; m_err = 0; m_end = 0; m_pts = 0; m_idle = 0;
            m_fase = FaseJoga;
          end
        end
        FaseJoga: begin
          ev  = jogada;
          err = jogada && (nota_jogada != seq[m_end]);
`ifdef TIMEOUT_JOGADA_EN
          if (jogada) m_idle = 0;
          else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
              ev = 1'b1; err = 1'b1; m_idle = 0;
            end
          end
`endif
          if (ev) begin
            if (err && m_err < 255) m_err++;
            if (m_end == m_rod) begin
              m_fase = FaseCalc;
              m_calc_rest = CALC_LAT;
            end else m_end++;
          end
        end
        FaseCalc: begin
          if (m_calc_rest == 1) m_fase = FaseReg;
          else m_calc_rest--;
        end
        FaseReg: begin
          m_pts = calc_inc ? (m_pts + 1) % 256 : int'(calc_val);
          m_err = 0; m_end = 0; m_idle = 0;
          if (m_rod == NUM_RODADAS - 1) m_fase = FaseFim;
          else begin
            m_rod++;
            m_fase = FaseJoga;
          end
        end
        default: m_fase = FaseOcioso;
      endcase
    end
  end

  always @(negedge clock) begin
    check("cmp_endereco", {4'h0, endereco}, 8'(m_end));
    check("cmp_rodada", {4'h0, rodada}, 8'(m_rod));
    check("cmp_erros", erros, 8'(m_err));
    check("cmp_pontos", pontos, 8'(m_pts));
    check("cmp_calcular", {7'h0, calcular}, {7'h0, m_fase == FaseCalc});
    check("cmp_ocupado", {7'h0, ocupado},
          {7'h0, m_fase == FaseJoga || m_fase == FaseCalc || m_fase == FaseReg});
    check("cmp_fim_jogo", {7'h0, fim_jogo}, {7'h0, m_fase == FaseFim});
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_iniciar();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
  endtask

  task automatic play(input logic [3:0] nota);
    jogada = 1'b1;
    nota_jogada = nota;
    tick();
    jogada = 1'b0;
  endtask

  task automatic finish_round();
    repeat (3) tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) seq[i] = 4'((i * 7 + 2) % 16);
    seq[0] = 4'h3;
    seq[1] = 4'h5;
    #1 reset_n = 1'b0;
    repeat (3) tick();
    check("reset_ocupado", {7'h0, ocupado}, 8'h00);
    check("reset_pontos", pontos, 8'h00);
    reset_n = 1'b1;
    tick();

    // Round 0, correct note.
    calc_val = 8'h0A;
    pulse_iniciar();
    check("r0_ocupado", {7'h0, ocupado}, 8'h01);
    play(4'h3);
    check("r0_calc1", {7'h0, calcular}, 8'h01);
    check("r0_rodada", {4'h0, rodada}, 8'h00);
    check("r0_erros", erros, 8'h00);
    tick();
    check("r0_calc2", {7'h0, calcular}, 8'h01);
    tick();
    check("r0_registra_calc", {7'h0, calcular}, 8'h00);
    tick();
    check("r0_pontos", pontos, 8'h0A);
    check("r0_next_rodada", {4'h0, rodada}, 8'h01);
    check("r0_endereco", {4'h0, endereco}, 8'h00);

    // Round 1, one wrong note; iniciar while busy is ignored.
    calc_val = 8'h14;
    play(4'h3);
    check("r1_endereco", {4'h0, endereco}, 8'h01);
    pulse_iniciar();
    check("busy_iniciar_rodada", {4'h0, rodada}, 8'h01);
    check("busy_iniciar_end", {4'h0, endereco}, 8'h01);
    play(4'h7);
    check("r1_erros_calc", erros, 8'h01);
    check("r1_calc", {7'h0, calcular}, 8'h01);
    jogada = 1'b1;
    nota_jogada = 4'hF;
    tick();
    check("ign_fr_erros", erros, 8'h01);
    check("ign_fr_end", {4'h0, endereco}, 8'h01);
    tick();
    check("ign_reg_erros", erros, 8'h01);
    check("ign_reg_end", {4'h0, endereco}, 8'h01);
    jogada = 1'b0;
    tick();
    check("r1_erros_after", erros, 8'h00);
    check("r1_next_rodada", {4'h0, rodada}, 8'h02);
    check("r1_pontos", pontos, 8'h14);

    // Round 2: iniciar together with jogada, jogada wins.
    iniciar = 1'b1;
    play(seq[0]);
    iniciar = 1'b0;
    check("sim_end", {4'h0, endereco}, 8'h01);
    check("sim_rodada", {4'h0, rodada}, 8'h02);
    play(seq[1]);
    play(seq[2]);
    finish_round();

    // Reset in the middle of round 3.
    check("r3_rodada", {4'h0, rodada}, 8'h03);
    play(seq[0]);
    #2 reset_n = 1'b0;
    #1;
    check("mid_reset_end", {4'h0, endereco}, 8'h00);
    check("mid_reset_rodada", {4'h0, rodada}, 8'h00);
    check("mid_reset_ocupado", {7'h0, ocupado}, 8'h00);
    check("mid_reset_pontos", pontos, 8'h00);
    @(posedge clock);
    #1 reset_n = 1'b1;
    tick();
    play(seq[0]);
    check("idle_jogada_end", {4'h0, endereco}, 8'h00);
    check("idle_ocupado", {7'h0, ocupado}, 8'h00);

    // Full game, calculator returns pontos+1.
    calc_inc = 1'b1;
    pulse_iniciar();
    for (int r = 0; r < NUM_RODADAS; r++) begin
      for (int i = 0; i <= r; i++) play(seq[i]);
      finish_round();
    end
    check("game_fim", {7'h0, fim_jogo}, 8'h01);
    check("game_ocupado", {7'h0, ocupado}, 8'h00);
    check("game_pontos", pontos, 8'h10);
    play(seq[0]);
    check("fim_jogada_end", {4'h0, endereco}, 8'h00);
    check("fim_pontos_hold", pontos, 8'h10);
    pulse_iniciar();
    check("restart_pontos", pontos, 8'h00);
    check("restart_fim", {7'h0, fim_jogo}, 8'h00);
    check("restart_ocupado", {7'h0, ocupado}, 8'h01);

`ifdef TIMEOUT_JOGADA_EN
    begin
      int n;
      play(seq[0]);
      finish_round();
      check("to_rodada", {4'h0, rodada}, 8'h01);
      repeat (TIMEOUT) tick();
      check("to_erros1", erros, 8'h01);
      check("to_end1", {4'h0, endereco}, 8'h01);
      n = 0;
      while (calcular !== 1'b1 && n < 15) begin
        tick();
        n++;
      end
      check("to_wait_cycles", 8'(n), 8'(TIMEOUT));
      check("to_erros2", erros, 8'h02);
    end
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/avaliador_rodada.md
Name: avaliador_rodada

Overview:
- Drives the score calculator's round interface; it is the requester side, and the calculator is the responder.
- Walks the player through rounds 0..NUM_RODADAS-1. Round r expects r+1 notes, read from the sequence memory.
- Counts wrong notes per round, then pulses calcular with a stable rodada/erros pair.
- Latches the calculator's result into the accumulated score register, which feeds back as the calculator's pontos_in.

Parameters:
- NOTA_W, 4, note code width
- NUM_RODADAS, 16, rounds per game (2..16)
- CALC_LAT, 2, cycles calcular is held high before the result is latched (>=1)
- TIMEOUT_CICLOS, 1000, idle cycles before a missed note counts as an error (only with the optional feature)

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- iniciar  in  1  start-game strobe
- jogada  in  1  one-cycle strobe; nota_jogada is valid in that cycle
- nota_jogada  in  NOTA_W  note played by the player
- nota_esperada  in  NOTA_W  sequence memory data at endereco (combinational read)
- pontos_calc  in  8  calculator result (pontos_out)
- endereco  out  4  sequence memory address (note index within the round)
- rodada  out  4  current round, to the calculator
- erros  out  8  errors in the current round, to the calculator
- calcular  out  1  calculator trigger
- pontos  out  8  accumulated score, to the calculator pontos_in
- ocupado  out  1  game in progress
- fim_jogo  out  1  game finished

Behaviour:
- Reset: while reset_n=0, every output is 0 and the state is OCIOSO, asynchronously. Reset mid-round drops calcular immediately and discards partial errors and the score.
- All outputs are registered.
- States: OCIOSO, ESPERA, FIM_RODADA, REGISTRA, FIM.
- OCIOSO (ocupado=0): on iniciar=1, clear rodada, erros, pontos, endereco and fim_jogo, set ocupado=1, go to ESPERA.
- ESPERA: on jogada=1, compare nota_jogada with nota_esperada in the same cycle.
  - Mismatch: erros += 1.
  - endereco==rodada: go to FIM_RODADA (endereco holds).
  - Otherwise: endereco += 1.
- FIM_RODADA: calcular=1 for exactly CALC_LAT consecutive cycles, then go to REGISTRA.
- REGISTRA: one cycle with calcular=0. At the end of this cycle:
  - pontos <= pontos_calc, erros <= 0, endereco <= 0.
  - If rodada==NUM_RODADAS-1: go to FIM.
  - Otherwise: rodada += 1 and go to ESPERA.
- rodada and erros are stable from the first calcular cycle through REGISTRA.
- FIM: fim_jogo=1, ocupado=0, pontos holds. iniciar=1 restarts exactly as from OCIOSO.
- jogada is ignored outside ESPERA. iniciar is ignored while ocupado=1.
- Simultaneous iniciar and jogada in ESPERA: iniciar is ignored and jogada is processed.
- erros saturates at 8'hFF. It never wraps.
- endereco and rodada never exceed NUM_RODADAS-1.

Optional Feature:
- Macro TIMEOUT_JOGADA_EN.
- Defined:
  - A 16-bit idle counter clears on entry to ESPERA and on every accepted jogada, and increments each cycle in ESPERA.
  - When it reaches TIMEOUT_CICLOS-1 with no jogada, that cycle is treated as a mismatching jogada: erros += 1 and endereco advances or the round ends, per the ESPERA rules. The counter then clears.
  - A jogada in the same cycle as the timeout takes priority; no timeout error is counted.
- Undefined: no counter is instantiated, and ESPERA waits indefinitely.

Test Plan:
1. Reset mid-round: drive reset_n=0 in the ESPERA state of round 3 -> all outputs are 0 in the same cycle; after release the state is OCIOSO and iniciar is needed to start.
2. Round 0 correct: iniciar; nota_esperada=4'h3; jogada with nota_jogada=4'h3; pontos_calc=8'h0A -> calcular high 2 cycles with rodada=0 and erros=0; then pontos=8'h0A, rodada=1, endereco=0.
3. Round 1 with one error: expected 3,5; played 3,7 -> erros=1 during calcular; erros=0 after REGISTRA; rodada=2.
4. Full game: 16 rounds all correct, with the bench model pontos_calc=pontos+1 -> fim_jogo=1 and ocupado=0 after round 15 with pontos=8'h10; a following iniciar clears pontos and fim_jogo.
5. Ignored events:
   - jogada strobes during FIM_RODADA/REGISTRA -> erros and endereco unchanged.
   - iniciar while ocupado=1 -> no restart.
6. With TIMEOUT_JOGADA_EN and TIMEOUT_CICLOS=10: round 1, no jogada for 10 cycles -> erros=1 and endereco=1. Another 10 idle cycles -> erros=2 and calcular asserts.
